// File: rtl/collision_event_manager.sv
// ---------------------------------------------------------------------------
// collision_event_manager
//
// Purpose:
//   Converts the per-pixel collision flags produced by game_controller into
//   frame-level game events. At most one shot hit and one tower hit are
//   recognised per frame. Tracks tower health, a short immunity window after
//   each damaging hit, the player score, and the PLAY / GAME_OVER state.
//
// Parameters:
//   MAX_HEALTH     tower health after reset or restart (1..15)
//   INVULN_FRAMES  frames of immunity after a damaging hit (0 = no immunity)
//   SCORE_STEP     score increment per shot hit (binary score only)
//   SCORE_W        score width (multiple of 4 when the BCD score is built)
//
// Build option:
//   SCORE_BCD_EN   when defined, score is packed BCD (digit 0 in [3:0]),
//                  each shot hit adds 1 with decimal carry and the score
//                  saturates at all-9s. When undefined, score is binary,
//                  adds SCORE_STEP and saturates at 2**SCORE_W-1.
//
// Ports:
//   clk                    in   system clock, all logic on its rising edge
//   resetN                 in   synchronous active-low reset
//   startOfFrame           in   one-cycle pulse at the start of each frame
//   ShotBoxCollision       in   per-pixel shot/tower overlap
//   TowerEnemyHUCollision  in   per-pixel enemy/tower overlap
//   restart                in   level request, honoured only in GAME_OVER
//   shot_hit_pulse         out  one-cycle pulse for the first shot hit of a frame
//   tower_hit_pulse        out  one-cycle pulse for a damaging tower hit
//   tower_health           out  remaining tower health
//   invulnerable           out  high while immunity frames are running
//   score                  out  accumulated score
//   game_over              out  high while in GAME_OVER
// ---------------------------------------------------------------------------
module collision_event_manager #(
  parameter int MAX_HEALTH    = 5,
  parameter int INVULN_FRAMES = 30,
  parameter int SCORE_STEP    = 10,
  parameter int SCORE_W       = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               ShotBoxCollision,
  input  logic               TowerEnemyHUCollision,
  input  logic               restart,
  output logic               shot_hit_pulse,
  output logic               tower_hit_pulse,
  output logic [3:0]         tower_health,
  output logic               invulnerable,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  // Immunity counter must hold INVULN_FRAMES; keep at least one bit so the
  // INVULN_FRAMES == 0 build still has a legal (unused) register.
  localparam int CNT_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

  localparam logic [3:0]       HEALTH_INIT = 4'(MAX_HEALTH);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(INVULN_FRAMES);

  typedef enum logic [0:0] {
    S_PLAY      = 1'b0,
    S_GAME_OVER = 1'b1
  } state_e;

  // -------------------------------------------------------------------------
  // State registers and their next-state values
  // -------------------------------------------------------------------------
  state_e             state_q,       state_d;
  logic               shot_seen_q,   shot_seen_d;
  logic               tower_seen_q,  tower_seen_d;
  logic               shot_pulse_q,  shot_pulse_d;
  logic               tower_pulse_q, tower_pulse_d;
  logic [3:0]         health_q,      health_d;
  logic               invuln_q,      invuln_d;
  logic [CNT_W-1:0]   cnt_q,         cnt_d;
  logic [SCORE_W-1:0] score_q,       score_d;

  // A collision coincident with startOfFrame belongs to the new frame, so the
  // frame flags are treated as already cleared in that cycle.
  logic shot_seen_eff;
  logic tower_seen_eff;
  logic shot_hit;
  logic tower_hit;

  assign shot_seen_eff  = startOfFrame ? 1'b0 : shot_seen_q;
  assign tower_seen_eff = startOfFrame ? 1'b0 : tower_seen_q;
  assign shot_hit       = ShotBoxCollision      && !shot_seen_eff;
  assign tower_hit      = TowerEnemyHUCollision && !tower_seen_eff;

  // -------------------------------------------------------------------------
  // Score increment with saturation
  // -------------------------------------------------------------------------
`ifdef SCORE_BCD_EN
  // Packed-BCD +1: ripple the carry through the digits; an all-9s score is
  // held rather than wrapping to zero.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] cur);
    logic [SCORE_W-1:0] nxt;
    logic               carry;
    logic               all_nines;
    nxt       = cur;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < SCORE_W / 4; i++) begin
      if (cur[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (cur[4*i +: 4] >= 4'd9) begin
          nxt[4*i +: 4] = 4'd0;
        end else begin
          nxt[4*i +: 4] = cur[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return all_nines ? cur : nxt;
  endfunction
`else
  localparam logic [SCORE_W:0] STEP_EXT  = (SCORE_W + 1)'(SCORE_STEP);
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  // Binary add one bit wider than the score so overflow is visible, then
  // clamp to the all-ones maximum.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] cur);
    logic [SCORE_W:0] sum;
    sum = {1'b0, cur} + STEP_EXT;
    if (sum > SCORE_MAX) sum = SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d       = state_q;
    shot_seen_d   = shot_seen_eff;
    tower_seen_d  = tower_seen_eff;
    shot_pulse_d  = 1'b0;
    tower_pulse_d = 1'b0;
    health_d      = health_q;
    invuln_d      = invuln_q;
    cnt_d         = cnt_q;
    score_d       = score_q;

    // Immunity countdown runs on frame boundaries; immunity ends on the edge
    // where the counter reaches zero.
    if (startOfFrame && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) invuln_d = 1'b0;
    end

    unique case (state_q)
      S_PLAY: begin
        if (shot_hit) begin
          shot_seen_d  = 1'b1;
          shot_pulse_d = 1'b1;
          score_d      = score_inc(score_q);
        end

        if (tower_hit) begin
          // The flag is set even when immune, so one contact still counts as
          // the frame's only tower event.
          tower_seen_d = 1'b1;
          if (!invuln_q) begin
            tower_pulse_d = 1'b1;
            if (health_q != 4'd0) health_d = health_q - 4'd1;
            if (INVULN_FRAMES > 0) begin
              invuln_d = 1'b1;
              cnt_d    = CNT_LOAD;
            end
            // Health reaching zero ends the game on the same edge; the hit
            // pulse for that final blow is still delivered.
            if (health_q <= 4'd1) state_d = S_GAME_OVER;
          end
        end
      end

      S_GAME_OVER: begin
        // Collisions are ignored here; only restart leaves this state.
        if (restart) begin
          state_d      = S_PLAY;
          health_d     = HEALTH_INIT;
          score_d      = '0;
          shot_seen_d  = 1'b0;
          tower_seen_d = 1'b0;
          invuln_d     = 1'b0;
          cnt_d        = '0;
        end
      end

      default: state_d = S_PLAY;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers (synchronous active-low reset, reset has top priority)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!resetN) begin
      state_q       <= S_PLAY;
      shot_seen_q   <= 1'b0;
      tower_seen_q  <= 1'b0;
      shot_pulse_q  <= 1'b0;
      tower_pulse_q <= 1'b0;
      health_q      <= HEALTH_INIT;
      invuln_q      <= 1'b0;
      cnt_q         <= '0;
      score_q       <= '0;
    end else begin
      state_q       <= state_d;
      shot_seen_q   <= shot_seen_d;
      tower_seen_q  <= tower_seen_d;
      shot_pulse_q  <= shot_pulse_d;
      tower_pulse_q <= tower_pulse_d;
      health_q      <= health_d;
      invuln_q      <= invuln_d;
      cnt_q         <= cnt_d;
      score_q       <= score_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs, all taken directly from registers
  // -------------------------------------------------------------------------
  assign shot_hit_pulse  = shot_pulse_q;
  assign tower_hit_pulse = tower_pulse_q;
  assign tower_health    = health_q;
  assign invulnerable    = invuln_q;
  assign score           = score_q;
  assign game_over       = (state_q == S_GAME_OVER);

endmodule

// File: tb/tb_collision_event_manager.sv
// ---------------------------------------------------------------------------
// tb_collision_event_manager
//
// Self-checking bench for collision_event_manager. Three instances share the
// stimulus:
//   dut_a  default parameters (MAX_HEALTH 5, INVULN_FRAMES 30, step 10)
//   dut_b  INVULN_FRAMES = 0, used for the run down to GAME_OVER and restart
//   dut_c  SCORE_W = 8, SCORE_STEP = 100, used for score saturation
// Each phase starts with a reset and checks only the instance it exercises.
// Honors SCORE_BCD_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_collision_event_manager;

`ifdef SCORE_BCD_EN
  localparam int A_STEP = 1;
`else
  localparam int A_STEP = 10;
`endif

  logic clk = 1'b0;
  logic resetN, sof, shot, tower, restart;

  logic        a_sp, a_tp, a_inv, a_go;
  logic [3:0]  a_hp;
  logic [15:0] a_score;
  logic        b_sp, b_tp, b_inv, b_go;
  logic [3:0]  b_hp;
  logic [15:0] b_score;
  logic        c_sp, c_tp, c_inv, c_go;
  logic [3:0]  c_hp;
  logic [7:0]  c_score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  collision_event_manager #(
    .MAX_HEALTH(5), .INVULN_FRAMES(30), .SCORE_STEP(10), .SCORE_W(16)
  ) dut_a (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .ShotBoxCollision(shot),
    .TowerEnemyHUCollision(tower), .restart(restart),
    .shot_hit_pulse(a_sp), .tower_hit_pulse(a_tp), .tower_health(a_hp),
    .invulnerable(a_inv), .score(a_score), .game_over(a_go)
  );

  collision_event_manager #(
    .MAX_HEALTH(5), .INVULN_FRAMES(0), .SCORE_STEP(10), .SCORE_W(16)
  ) dut_b (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .ShotBoxCollision(shot),
    .TowerEnemyHUCollision(tower), .restart(restart),
    .shot_hit_pulse(b_sp), .tower_hit_pulse(b_tp), .tower_health(b_hp),
    .invulnerable(b_inv), .score(b_score), .game_over(b_go)
  );

  collision_event_manager #(
    .MAX_HEALTH(3), .INVULN_FRAMES(2), .SCORE_STEP(100), .SCORE_W(8)
  ) dut_c (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .ShotBoxCollision(shot),
    .TowerEnemyHUCollision(tower), .restart(restart),
    .shot_hit_pulse(c_sp), .tower_hit_pulse(c_tp), .tower_health(c_hp),
    .invulnerable(c_inv), .score(c_score), .game_over(c_go)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sof = 1'b0; shot = 1'b0; tower = 1'b0; restart = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
  endtask

  // One frame start followed by an optional collision cycle.
  task automatic frame_then(input logic s, input logic t);
    sof = 1'b1; step(); sof = 1'b0;
    shot = s; tower = t; step(); shot = 1'b0; tower = 1'b0;
  endtask

  typedef struct packed {
    logic        rstn, sof, shot, tower, rst;   // applied before the edge
    logic        sp, tp;                        // expected after the edge
    logic [3:0]  hp;
    logic        inv;
    logic [15:0] score;
    logic        go;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    int pulses;

    resetN = 1'b0;
    clear_inputs();

    //           rstn  sof   shot  tower rst   sp    tp    hp    inv   score                go
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 16'(0),              1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 16'(0),              1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 16'(A_STEP),         1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 16'(A_STEP),         1'b0};
    // shot in the same cycle as startOfFrame with shot_seen still set
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b0, 16'(2*A_STEP),       1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 16'(2*A_STEP),       1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 16'(2*A_STEP),       1'b0};
    // new frame but immune: no damage
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 16'(2*A_STEP),       1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1, 16'(3*A_STEP),       1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1, 16'(4*A_STEP),       1'b0};
    // reset mid-immunity with collisions present
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 16'(0),              1'b0};
    // shot and tower together, both pulses
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 16'(A_STEP),         1'b0};
    // restart is ignored in PLAY
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 16'(A_STEP),         1'b0};

    step();
    step();

    // ---- table-driven vectors on dut_a ----
    for (int i = 0; i < NV; i++) begin
      resetN = vecs[i].rstn; sof = vecs[i].sof; shot = vecs[i].shot;
      tower = vecs[i].tower; restart = vecs[i].rst;
      step();
      check($sformatf("v%0d shot_hit_pulse", i),  32'(a_sp),    32'(vecs[i].sp));
      check($sformatf("v%0d tower_hit_pulse", i), 32'(a_tp),    32'(vecs[i].tp));
      check($sformatf("v%0d tower_health", i),    32'(a_hp),    32'(vecs[i].hp));
      check($sformatf("v%0d invulnerable", i),    32'(a_inv),   32'(vecs[i].inv));
      check($sformatf("v%0d score", i),           32'(a_score), 32'(vecs[i].score));
      check($sformatf("v%0d game_over", i),       32'(a_go),    32'(vecs[i].go));
    end
    clear_inputs();
    resetN = 1'b1;

    // ---- shot held for 200 cycles in one frame: exactly one pulse ----
    do_reset();
    sof = 1'b1; step(); sof = 1'b0;
    shot = 1'b1;
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (a_sp) pulses++;
    end
    shot = 1'b0;
    check("hold200 pulses", 32'(pulses), 32'd1);
    check("hold200 score", 32'(a_score), 32'(A_STEP));

    // ---- immunity window: 30 frames ----
    do_reset();
    frame_then(1'b0, 1'b1);
    check("immune hit pulse", 32'(a_tp), 32'd1);
    check("immune hit health", 32'(a_hp), 32'd4);
    check("immune set", 32'(a_inv), 32'd1);
    step();
    check("immune pulse width", 32'(a_tp), 32'd0);
    for (int f = 1; f <= 30; f++) begin
      sof = 1'b1; step(); sof = 1'b0;
      if (f == 2) begin
        tower = 1'b1; step(); tower = 1'b0;
        check("frame3 hit pulse", 32'(a_tp), 32'd0);
        check("frame3 hit health", 32'(a_hp), 32'd4);
      end
      if (f == 29) check("immune after 29 frames", 32'(a_inv), 32'd1);
      if (f == 30) check("immune after 30 frames", 32'(a_inv), 32'd0);
    end
    tower = 1'b1; step(); tower = 1'b0;
    check("post-immune hit pulse", 32'(a_tp), 32'd1);
    check("post-immune health", 32'(a_hp), 32'd3);

    // ---- no immunity: run to GAME_OVER, then restart (dut_b) ----
    do_reset();
    frame_then(1'b1, 1'b0);
    check("b score", 32'(b_score), 32'(A_STEP));
    restart = 1'b1; step(); restart = 1'b0;
    check("b restart in PLAY score", 32'(b_score), 32'(A_STEP));
    check("b restart in PLAY health", 32'(b_hp), 32'd5);
    for (int k = 1; k <= 5; k++) begin
      frame_then(1'b0, 1'b1);
      check($sformatf("b hit%0d pulse", k), 32'(b_tp), 32'd1);
      check($sformatf("b hit%0d health", k), 32'(b_hp), 32'(5 - k));
      check($sformatf("b hit%0d game_over", k), 32'(b_go), (k == 5) ? 32'd1 : 32'd0);
    end
    check("b never immune", 32'(b_inv), 32'd0);
    frame_then(1'b1, 1'b1);
    check("b over tower pulse", 32'(b_tp), 32'd0);
    check("b over shot pulse", 32'(b_sp), 32'd0);
    check("b over health", 32'(b_hp), 32'd0);
    check("b over score held", 32'(b_score), 32'(A_STEP));
    check("b over state", 32'(b_go), 32'd1);
    restart = 1'b1; step(); restart = 1'b0;
    check("b restart health", 32'(b_hp), 32'd5);
    check("b restart score", 32'(b_score), 32'd0);
    check("b restart game_over", 32'(b_go), 32'd0);
    frame_then(1'b0, 1'b1);
    check("b replay hit pulse", 32'(b_tp), 32'd1);

    // ---- score saturation (dut_c, 8-bit score) ----
    do_reset();
`ifdef SCORE_BCD_EN
    for (int h = 1; h <= 100; h++) begin
      frame_then(1'b1, 1'b0);
      if (h == 9)   check("c bcd 09", 32'(c_score), 32'h09);
      if (h == 10)  check("c bcd carry 10", 32'(c_score), 32'h10);
      if (h == 99)  check("c bcd 99", 32'(c_score), 32'h99);
      if (h == 100) check("c bcd saturate", 32'(c_score), 32'h99);
    end
`else
    for (int h = 1; h <= 4; h++) begin
      frame_then(1'b1, 1'b0);
      check($sformatf("c bin score hit%0d", h), 32'(c_score), (h * 100 > 255) ? 32'd255 : 32'(h * 100));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
